// File: rtl/divisor_secuencial.sv
// rtl/divisor_secuencial.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
module divisor_secuencial #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividendo,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] cociente,
  output logic [N-1:0] residuo,
  output logic         div_cero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N:0]     r_q, r_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   d_q, d_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N-1:0]   cociente_q, cociente_d;
  logic [N-1:0]   residuo_q, residuo_d;
  logic           div_cero_q, div_cero_d;

  // Shifted partial remainder and the N+1-bit trial subtraction; the MSB is the borrow.
  logic [N:0]     shifted;
  logic [N:0]     trial;

  // Next-state and datapath: load on start, one restoring step per CALC cycle.
  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    q_d        = q_q;
    d_d        = d_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cociente_d = cociente_q;
    residuo_d  = residuo_q;
    div_cero_d = div_cero_q;
    shifted    = {r_q[N-1:0], q_q[N-1]};
    trial      = shifted - {1'b0, d_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            d_d        = divisor;
            q_d        = dividendo;
            r_d        = '0;
            cnt_d      = CW'(N);
            busy_d     = 1'b1;
            div_cero_d = 1'b0;
            state_d    = CALC;
          end else begin
            // Divide by zero finishes immediately without entering CALC.
            cociente_d = '1;
            residuo_d  = dividendo;
            div_cero_d = 1'b1;
            done_d     = 1'b1;
          end
        end
      end
      CALC: begin
        if (trial[N]) begin
          r_d = shifted;
        end else begin
          r_d = trial;
        end
        q_d   = {q_q[N-2:0], ~trial[N]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          cociente_d = q_d;
          residuo_d  = r_d[N-1:0];
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset abandons any sequence in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      r_q        <= '0;
      q_q        <= '0;
      d_q        <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cociente_q <= '0;
      residuo_q  <= '0;
      div_cero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      q_q        <= q_d;
      d_q        <= d_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cociente_q <= cociente_d;
      residuo_q  <= residuo_d;
      div_cero_q <= div_cero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign cociente = cociente_q;
  assign residuo  = residuo_q;
  assign div_cero = div_cero_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// tb/tb_divisor_secuencial.sv - directed and random checks of divisor_secuencial
module tb_divisor_secuencial;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividendo;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] cociente;
  logic [N-1:0] residuo;
  logic         div_cero;

  int vectors;
  int miscompares;

  divisor_secuencial #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .cociente  (cociente),
    .residuo   (residuo),
    .div_cero  (div_cero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called on a negedge; drives start through one rising edge (E0) and returns on the next negedge.
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
    start     = 1'b1;
    dividendo = a;
    divisor   = b;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
  endtask

  // From the negedge after E0, count rising edges until done and the cycles busy was high.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bcnt;
    int spurious;
    logic [N-1:0] a;
    logic [N-1:0] b;

    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    dividendo   = '0;
    divisor     = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cociente", cociente, 0);
    chk("rst_residuo", residuo, 0);
    chk("rst_div_cero", div_cero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 100 / 7
    launch(8'd100, 8'd7);
    wait_done(lat, bcnt);
    chk("t1_latency", lat, 8);
    chk("t1_busy_cycles", bcnt, 8);
    chk("t1_busy_at_done", busy, 0);
    chk("t1_cociente", cociente, 14);
    chk("t1_residuo", residuo, 2);
    chk("t1_div_cero", div_cero, 0);
    @(negedge clk);
    chk("t1_done_one_cycle", done, 0);
    chk("t1_cociente_hold", cociente, 14);

    // Directed corner cases
    launch(8'd255, 8'd1);
    wait_done(lat, bcnt);
    chk("t2a_cociente", cociente, 255);
    chk("t2a_residuo", residuo, 0);
    @(negedge clk);
    launch(8'd5, 8'd9);
    wait_done(lat, bcnt);
    chk("t2b_cociente", cociente, 0);
    chk("t2b_residuo", residuo, 5);
    @(negedge clk);
    launch(8'd200, 8'd200);
    wait_done(lat, bcnt);
    chk("t2c_cociente", cociente, 1);
    chk("t2c_residuo", residuo, 0);
    @(negedge clk);
    launch(8'd255, 8'd128);
    wait_done(lat, bcnt);
    chk("t2d_cociente", cociente, 1);
    chk("t2d_residuo", residuo, 127);
    @(negedge clk);
    launch(8'd0, 8'd3);
    wait_done(lat, bcnt);
    chk("t2e_cociente", cociente, 0);
    chk("t2e_residuo", residuo, 0);
    @(negedge clk);

    // Random nonzero divisors against a / b, a % b
    for (int i = 0; i < 1000; i++) begin
      a = N'($urandom_range(0, 255));
      b = N'($urandom_range(1, 255));
      launch(a, b);
      wait_done(lat, bcnt);
      chk("rnd_latency", lat, 8);
      chk("rnd_cociente", cociente, a / b);
      chk("rnd_residuo", residuo, a % b);
      @(negedge clk);
    end

    // Divide by zero
    launch(8'd42, 8'd0);
    wait_done(lat, bcnt);
    chk("t3_latency", lat, 0);
    chk("t3_busy", busy, 0);
    chk("t3_cociente", cociente, 255);
    chk("t3_residuo", residuo, 42);
    chk("t3_div_cero", div_cero, 1);
    @(negedge clk);
    chk("t3_done_one_cycle", done, 0);
    chk("t3_busy_after", busy, 0);
    chk("t3_div_cero_hold", div_cero, 1);

    // start during CALC is ignored
    launch(8'd100, 8'd7);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    start     = 1'b1;
    dividendo = 8'd50;
    divisor   = 8'd5;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    wait_done(lat, bcnt);
    chk("t4_latency", lat + 3, 8);
    chk("t4_cociente", cociente, 14);
    chk("t4_residuo", residuo, 2);
    chk("t4_div_cero", div_cero, 0);
    @(negedge clk);

    // Back-to-back: start held in the done cycle
    launch(8'd100, 8'd7);
    wait_done(lat, bcnt);
    chk("t5_first_cociente", cociente, 14);
    launch(8'd50, 8'd5);
    chk("t5_done_dropped", done, 0);
    chk("t5_busy_again", busy, 1);
    wait_done(lat, bcnt);
    chk("t5_latency", lat, 8);
    chk("t5_cociente", cociente, 10);
    chk("t5_residuo", residuo, 0);
    @(negedge clk);

    // Reset mid-operation
    launch(8'd100, 8'd7);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_cociente", cociente, 0);
    chk("t6_residuo", residuo, 0);
    chk("t6_div_cero", div_cero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) spurious++;
    end
    chk("t6_no_spurious_done", spurious, 0);
    chk("t6_cociente_after", cociente, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
